// File: rtl/axil_stream_bridge.sv
// AXI4-Lite slave bridging TX_DATA writes to an m_axis FIFO and s_axis words into a one-word RX_DATA register.
// Latency: awready/arready 1 cycle after request, bvalid/rvalid 1 cycle after accept; pushed TX word on m_axis next cycle.
// Backpressure: full TX FIFO drops writes; s_axis stalls while RX holds a word. AXIL_ERR_RESP_EN enables SLVERR responses.

module axil_stream_bridge_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    output logic                   wr_rdy,
    output logic                   rd_vld,
    output logic [W-1:0]           rd_dat,
    input  logic                   rd_rdy,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full   = (count == CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
    assign pop    = rd_vld && rd_rdy;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign wr_rdy = !full || pop;
    assign push   = wr_vld && wr_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module axil_stream_bridge #(
    parameter int TX_DEPTH = 4,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready
);
    localparam int         CNT_W       = $clog2(TX_DEPTH) + 1;
    localparam logic [1:0] A_TX        = 2'd0;
    localparam logic [1:0] A_RX        = 2'd1;
    localparam logic [1:0] A_ST        = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic             aw_acc;
    logic             ar_acc;
    logic             tx_push;
    logic             tx_rdy;
    logic             tx_full;
    logic             tx_empty;
    logic [CNT_W-1:0] tx_count;
    logic [4:0]       tx_count5;
    logic             rx_valid;
    logic [31:0]      rx_data;
    logic             rx_pop;
    logic [1:0]       wr_sel;
    logic [1:0]       rd_sel;
    logic [1:0]       wr_resp;
    logic [1:0]       rd_resp;
    logic [31:0]      status;
    logic [31:0]      rd_mux;
    logic             aw_req;
    logic             unused_ok;

    assign wr_sel    = s_axil_awaddr[3:2];
    assign rd_sel    = s_axil_araddr[3:2];
    assign aw_acc    = s_axil_awready && s_axil_awvalid && s_axil_wvalid;
    assign ar_acc    = s_axil_arready && s_axil_arvalid;
    assign aw_req    = s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid && !s_axil_awready;
    assign tx_push   = aw_acc && (wr_sel == A_TX);
    assign rx_pop    = ar_acc && (rd_sel == A_RX) && rx_valid;
    assign s_axis_tready = !rx_valid || rx_pop;
    assign tx_empty  = !m_axis_tvalid;
    assign tx_count5 = 5'(tx_count);
    assign status    = {19'd0, tx_count5, 5'd0, rx_valid, tx_empty, tx_full};
    assign unused_ok = ^{s_axil_wstrb, s_axil_awaddr, s_axil_araddr, tx_rdy};

    axil_stream_bridge_fifo #(
        .W     (32),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (tx_push),
        .wr_dat  (s_axil_wdata),
        .wr_rdy  (tx_rdy),
        .rd_vld  (m_axis_tvalid),
        .rd_dat  (m_axis_tdata),
        .rd_rdy  (m_axis_tready),
        .full    (tx_full),
        .count   (tx_count)
    );

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            A_RX:    rd_mux = rx_valid ? rx_data : '0;
            A_ST:    rd_mux = status;
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        wr_resp = RESP_OKAY;
        rd_resp = RESP_OKAY;
`ifdef AXIL_ERR_RESP_EN
        if ((wr_sel != A_TX) || !tx_rdy) wr_resp = RESP_SLVERR;
        if ((rd_sel == 2'd3) || ((rd_sel == A_RX) && !rx_valid)) rd_resp = RESP_SLVERR;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
            rx_valid       <= 1'b0;
            rx_data        <= '0;
        end else begin
            // Ready is a registered single-cycle pulse; the accept happens while it is high.
            s_axil_awready <= aw_req;
            s_axil_wready  <= aw_req;
            if (aw_acc) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_resp;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end

            s_axil_arready <= s_axil_arvalid && !s_axil_rvalid && !s_axil_arready;
            if (ar_acc) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_mux;
                s_axil_rresp  <= rd_resp;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end

            // A capture in the pop cycle takes priority so the new word is kept.
            if (s_axis_tvalid && s_axis_tready) begin
                rx_valid <= 1'b1;
                rx_data  <= s_axis_tdata;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule
